// File: rtl/aq_mem_arbiter.sv
// aq_mem_arbiter: shares one single-port RAM between a CPU slot, a loader
// write FIFO and a tape read FSM. The CPU has priority, but if the loader or
// tape has waited STARVE_LIM cycles the next CPU slot is stolen (cpu_stall).
//
// Ports:
//   clk_sys, reset_n              clock, async active-low reset
//   cpu_ce/addr/we/wdata/rdata    CPU slot access; rdata registered
//   cpu_stall                     one-cycle slot steal indicator
//   ld_wr/addr/data               loader write strobe into the FIFO
//   ld_busy, ld_overflow          FIFO full, sticky dropped-write flag
//   tp_req/addr, tp_ack/data      tape read handshake (level req, pulse ack)
//   mem_addr/we/wdata/rdata       RAM port; rdata valid one cycle after addr
module aq_mem_arbiter #(
    parameter int AW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_ce,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_busy,
    output logic          ld_overflow,
    input  logic          tp_req,
    input  logic [AW-1:0] tp_addr,
    output logic          tp_ack,
    output logic [7:0]    tp_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIM      = SW'(STARVE_LIM);

    typedef enum logic [1:0] {T_IDLE, T_PEND, T_DATA, T_ACK} tp_state_t;

    // ---------------- state ----------------
    logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [7:0]      r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_overflow;
    logic [SW-1:0]   r_starve;
    logic            r_stall;
    logic            r_cpu_rd_pend;
    logic [7:0]      r_cpu_rdata;
    logic [7:0]      r_tp_data;
    logic [AW-1:0]   r_hold_addr;
    tp_state_t       r_tp_state;

    // ---------------- grant ----------------
    logic            w_full, w_empty;
    logic            w_cpu_gnt, w_ld_gnt, w_tp_gnt, w_tp_pend, w_pending;
    logic            w_push, w_drop, w_we;
    logic [SW-1:0]   w_starve_nxt;
    tp_state_t       w_tp_next;

    assign w_full    = (r_cnt == FULL_CNT);
    assign w_empty   = (r_cnt == '0);
    assign w_tp_pend = (r_tp_state == T_PEND) && tp_req;
    assign w_cpu_gnt = cpu_ce && !r_stall;
    assign w_ld_gnt  = !w_cpu_gnt && !w_empty;
    assign w_tp_gnt  = !w_cpu_gnt && w_empty && w_tp_pend;
    assign w_pending = !w_empty || w_tp_pend;

    // A pop in the same cycle frees the slot the push lands in.
    assign w_push = ld_wr && (!w_full || w_ld_gnt);
    assign w_drop = ld_wr && w_full && !w_ld_gnt;

    always_comb begin
        mem_addr  = r_hold_addr;
        w_we      = 1'b0;
        mem_wdata = 8'h00;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            w_we      = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (w_ld_gnt) begin
            mem_addr  = r_fifo_addr[r_rd_ptr];
            w_we      = 1'b1;
            mem_wdata = r_fifo_data[r_rd_ptr];
        end else if (w_tp_gnt) begin
            mem_addr  = tp_addr;
        end
    end

    // Keep the RAM write enable low for as long as reset is held.
    assign mem_we = w_we && reset_n;

    // Address holds when nobody owns the port.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_hold_addr <= '0;
        else if (w_cpu_gnt || w_ld_gnt || w_tp_gnt)
            r_hold_addr <= mem_addr;
    end

    // ---------------- loader FIFO ----------------
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= ld_addr;
            r_fifo_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_ld_gnt) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_ld_gnt})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign ld_busy     = w_full;
    assign ld_overflow = r_overflow;

    // ---------------- CPU read return ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_rd_pend <= 1'b0;
            r_cpu_rdata   <= 8'h00;
        end else begin
            r_cpu_rd_pend <= w_cpu_gnt && !cpu_we;
            if (r_cpu_rd_pend) r_cpu_rdata <= mem_rdata;
        end
    end

    assign cpu_rdata = r_cpu_rdata;

    // ---------------- tape FSM ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tp_state <= T_IDLE;
            r_tp_data  <= 8'h00;
        end else begin
            r_tp_state <= w_tp_next;
            if (r_tp_state == T_DATA) r_tp_data <= mem_rdata;
        end
    end

    always_comb begin
        w_tp_next = r_tp_state;
        case (r_tp_state)
            T_IDLE:  if (tp_req) w_tp_next = T_PEND;
            T_PEND: begin
                if (!tp_req)       w_tp_next = T_IDLE;
                else if (w_tp_gnt) w_tp_next = T_DATA;
            end
            T_DATA:  w_tp_next = T_ACK;
            T_ACK:   w_tp_next = T_IDLE;
            default: w_tp_next = T_IDLE;
        endcase
    end

    assign tp_ack  = (r_tp_state == T_ACK);
    assign tp_data = r_tp_data;

    // ---------------- starvation / slot steal ----------------
    // The counter only reaches LIM in the cycle that sets the stall, so the
    // stall cycle itself always clears it and a second stall needs LIM more
    // waiting cycles.
    always_comb begin
        w_starve_nxt = r_starve;
        if (r_stall || w_ld_gnt || w_tp_gnt)
            w_starve_nxt = '0;
        else if (w_pending && r_starve != LIM)
            w_starve_nxt = r_starve + 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            r_stall  <= !r_stall && (w_starve_nxt == LIM);
        end
    end

    assign cpu_stall = r_stall;

endmodule

// File: tb/tb_aq_mem_arbiter.sv
// Bench for aq_mem_arbiter: a RAM behind the memory port, a transaction-level
// reference (queue for the loader FIFO, phase counter for tape, plain integer
// starvation count) compared on every falling edge, plus directed scenarios
// with literal expected values.
module tb_aq_mem_arbiter;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          cpu_ce, cpu_we, ld_wr, tp_req;
    logic [AW-1:0] cpu_addr, ld_addr, tp_addr;
    logic [7:0]    cpu_wdata, ld_data;
    logic [7:0]    cpu_rdata, tp_data, mem_wdata, mem_rdata;
    logic          cpu_stall, ld_busy, ld_overflow, tp_ack, mem_we;
    logic [AW-1:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    aq_mem_arbiter #(.AW(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_busy(ld_busy), .ld_overflow(ld_overflow),
        .tp_req(tp_req), .tp_addr(tp_addr), .tp_ack(tp_ack), .tp_data(tp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM behind the port: one-cycle read latency.
    logic [7:0] ram  [0:65535];
    logic [7:0] mram [0:65535];
    always @(posedge clk_sys) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 7 + (a >> 8)) & 255);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q_a [$];
    logic [7:0]  q_d [$];
    int          tph;          // 0 idle, 1 waiting, 2 data, 3 ack
    logic [7:0]  m_tpval, m_tpdata, m_cpu_rdata, m_rd_val;
    bit          m_rd_pend, m_ovf, m_stall;
    int          m_starve;
    logic [15:0] m_last;

    always @(negedge clk_sys) begin : model
        bit          cg, lg, tg, tpend, pend;
        logic [15:0] ea;
        bit          ewe;
        logic [7:0]  ewd;
        if (!reset_n) begin
            q_a.delete(); q_d.delete();
            tph = 0; m_tpdata = 0; m_cpu_rdata = 0; m_rd_pend = 0;
            m_ovf = 0; m_stall = 0; m_starve = 0; m_last = 0;
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_tp_data", tp_data, 0);
            chk("rst_tp_ack", tp_ack, 0);
            chk("rst_cpu_stall", cpu_stall, 0);
            chk("rst_ld_overflow", ld_overflow, 0);
            chk("rst_ld_busy", ld_busy, 0);
            chk("rst_mem_we", mem_we, 0);
        end else begin
            tpend = (tph == 1) && tp_req;
            pend  = (q_a.size() > 0) || tpend;
            cg = cpu_ce && !m_stall;
            lg = !cg && q_a.size() > 0;
            tg = !cg && !lg && tpend;
            ewe = cg ? cpu_we : lg;
            ea  = cg ? cpu_addr : lg ? q_a[0] : tg ? tp_addr : m_last;
            ewd = cg ? cpu_wdata : lg ? q_d[0] : 8'h00;

            chk("mem_addr", mem_addr, ea);
            chk("mem_we", mem_we, ewe);
            if (ewe) chk("mem_wdata", mem_wdata, ewd);
            chk("cpu_stall", cpu_stall, m_stall);
            chk("ld_busy", ld_busy, q_a.size() == DEPTH);
            chk("ld_overflow", ld_overflow, m_ovf);
            chk("tp_ack", tp_ack, tph == 3);
            chk("tp_data", tp_data, m_tpdata);
            chk("cpu_rdata", cpu_rdata, m_cpu_rdata);

            // advance to the state after this clock edge
            if (m_rd_pend) m_cpu_rdata = m_rd_val;
            m_rd_pend = cg && !cpu_we;
            m_rd_val  = mram[cpu_addr];
            if (cg || lg || tg) m_last = ea;
            case (tph)
                0: if (tp_req) tph = 1;
                1: if (!tp_req) tph = 0;
                   else if (tg) begin tph = 2; m_tpval = mram[tp_addr]; end
                2: begin m_tpdata = m_tpval; tph = 3; end
                default: tph = 0;
            endcase
            if (cg && cpu_we) mram[cpu_addr] = cpu_wdata;
            if (lg) begin
                mram[q_a[0]] = q_d[0];
                void'(q_a.pop_front()); void'(q_d.pop_front());
            end
            if (ld_wr) begin
                if (q_a.size() < DEPTH) begin q_a.push_back(ld_addr); q_d.push_back(ld_data); end
                else m_ovf = 1;
            end
            if (m_stall || lg || tg) m_starve = 0;
            else if (pend) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            m_stall = !m_stall && (m_starve == LIM);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic at_neg();
        @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        n_fail++;
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = init_val(i);
            mram[i] = init_val(i);
        end
        ram[16'h1234] = 8'hA5; mram[16'h1234] = 8'hA5;
        ram[16'h0010] = 8'h3C; mram[16'h0010] = 8'h3C;
        reset_n = 0; cpu_ce = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_wr = 0; ld_addr = 0; ld_data = 0; tp_req = 0; tp_addr = 0;
        repeat (3) tick();
        at_neg();
        chk("reset_mem_addr", mem_addr, 0);
        tick();

        // CPU read issued as reset releases: data two edges later
        reset_n = 1; cpu_ce = 1; cpu_addr = 16'h1234; cpu_we = 0;
        tick(); cpu_ce = 0;
        tick(); at_neg();
        chk("cpu_read_A5", cpu_rdata, 8'hA5);

        // CPU write then read back
        tick(); cpu_ce = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
        tick(); cpu_we = 0;
        tick(); cpu_ce = 0;
        tick(); at_neg();
        chk("cpu_wr_rd_5A", cpu_rdata, 8'h5A);

        // Tape read on idle bus
        tick(); tp_req = 1; tp_addr = 16'h0010;
        tick(); at_neg(); chk("tape_grant_addr", mem_addr, 16'h0010);
        tick(); at_neg(); chk("tape_ack_early", tp_ack, 0);
        tick(); at_neg(); chk("tape_ack", tp_ack, 1); chk("tape_data_3C", tp_data, 8'h3C);
        tick(); tp_req = 0; at_neg(); chk("tape_ack_once", tp_ack, 0);
        chk("tape_data_hold", tp_data, 8'h3C);

        // Contention: loader entry beats tape, tape next cycle
        tick(); ld_wr = 1; ld_addr = 16'h0300; ld_data = 8'h77; tp_req = 1; tp_addr = 16'h0300;
        tick(); ld_wr = 0; at_neg();
        chk("cont_ld_we", mem_we, 1); chk("cont_ld_addr", mem_addr, 16'h0300);
        tick(); at_neg(); chk("cont_tp_we", mem_we, 0);
        tick();
        tick(); at_neg(); chk("cont_tp_ack", tp_ack, 1); chk("cont_tp_data", tp_data, 8'h77);
        tick(); tp_req = 0;

        // Loader burst of 6 against a busy CPU
        tick(); cpu_ce = 1; cpu_we = 0; cpu_addr = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            ld_wr = 1; ld_addr = 16'h0400 + 16'(i); ld_data = 8'h10 + 8'(i);
            if (i == 4) begin at_neg(); chk("burst_busy", ld_busy, 1); end
            if (i == 5) begin at_neg(); chk("burst_overflow", ld_overflow, 1); end
            tick();
        end
        ld_wr = 0;
        tick();
        tick(); at_neg(); chk("burst_no_stall_c8", cpu_stall, 0);
        tick(); at_neg(); chk("burst_stall_c9", cpu_stall, 1);
        chk("burst_steal_addr", mem_addr, 16'h0400); chk("burst_steal_we", mem_we, 1);
        repeat (40) tick();
        cpu_ce = 1; cpu_addr = 16'h0403;
        tick(); cpu_ce = 0;
        tick(); at_neg(); chk("burst_last_kept", cpu_rdata, 8'h13);
        tick(); cpu_ce = 1; cpu_addr = 16'h0404;
        tick(); cpu_ce = 0;
        tick(); at_neg(); chk("burst_dropped", cpu_rdata, init_val(16'h0404));

        // Reset while tape read is in its data phase
        tick(); tp_req = 1; tp_addr = 16'h0500;
        tick(); ld_wr = 1; ld_addr = 16'h0600; ld_data = 8'h99;
        tick(); ld_wr = 0; reset_n = 0; tp_req = 0; cpu_addr = 0; at_neg();
        chk("rstd_busy", ld_busy, 0); chk("rstd_we", mem_we, 0);
        chk("rstd_addr", mem_addr, 0); chk("rstd_tp_data", tp_data, 0);
        chk("rstd_cpu_rdata", cpu_rdata, 0); chk("rstd_ovf", ld_overflow, 0);
        tick(); reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            at_neg(); chk("rstd_no_ack", tp_ack, 0); tick();
        end

        // Push and pop together while full
        cpu_ce = 1; cpu_addr = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            ld_wr = 1; ld_addr = 16'h0500 + 16'(i); ld_data = 8'h20 + 8'(i);
            tick();
        end
        cpu_ce = 0; ld_wr = 1; ld_addr = 16'h0504; ld_data = 8'h24;
        at_neg(); chk("pp_full", ld_busy, 1); chk("pp_pop0", mem_addr, 16'h0500);
        tick(); ld_wr = 0; at_neg();
        chk("pp_still_full", ld_busy, 1); chk("pp_no_ovf", ld_overflow, 0);
        chk("pp_pop1", mem_addr, 16'h0501);
        repeat (6) tick();
        cpu_ce = 1; cpu_addr = 16'h0504;
        tick(); cpu_ce = 0;
        tick(); at_neg(); chk("pp_last_entry", cpu_rdata, 8'h24);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
